// File: rtl/i2c_target.sv
// i2c_target: I2C target exposing an 8-bit register pointer
// and a byte-wide write/read strobe port; SDA is open-drain.
// Ports: iCLK/iRST_N clock and sync active-low reset;
//   I2C_SCL/I2C_SDA bus; REG_ADDR pointer; REG_WDATA/REG_WE
//   write port; REG_RDATA/REG_RE read port; BUSY in-transfer.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h39,
  parameter int         FILTER   = 4
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCL,
  inout  wire        I2C_SDA,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       REG_WE,
  input  logic [7:0] REG_RDATA,
  output logic       REG_RE,
  output logic       BUSY
);

  localparam int CW = (FILTER < 2) ? 1 : $clog2(FILTER);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_ACK_DEV, S_SUB, S_ACK_SUB,
    S_WR, S_ACK_WR, S_RD, S_RD_ACK, S_IGNORE
  } state_t;

  logic [1:0]    r_scl_s, r_sda_s;
  logic [CW-1:0] r_scl_cnt, r_sda_cnt;
  logic          r_scl_f, r_sda_f, r_scl_d, r_sda_d;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_bitcnt, w_bitcnt_nxt;
  logic [6:0]  r_shift, w_shift_nxt;
  logic [6:0]  r_tx, w_tx_nxt;
  logic        r_oe, w_oe_nxt;
  logic        r_ackd, w_ackd_nxt;
  logic        r_rw, w_rw_nxt;
  logic [7:0]  r_addr, w_addr_nxt;
  logic [7:0]  r_wdata, w_wdata_nxt;
  logic        r_we, w_we_nxt;
  logic        r_re, w_re_nxt;
  logic        r_busy, w_busy_nxt;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte;

  // A level change is accepted only after FILTER
  // consecutive differing samples.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_scl_s   <= 2'b11;
      r_sda_s   <= 2'b11;
      r_scl_f   <= 1'b1;
      r_sda_f   <= 1'b1;
      r_scl_d   <= 1'b1;
      r_sda_d   <= 1'b1;
      r_scl_cnt <= '0;
      r_sda_cnt <= '0;
    end else begin
      r_scl_s <= {r_scl_s[0], I2C_SCL};
      r_sda_s <= {r_sda_s[0], I2C_SDA};
      r_scl_d <= r_scl_f;
      r_sda_d <= r_sda_f;
      if (r_scl_s[1] == r_scl_f) begin
        r_scl_cnt <= '0;
      end else if (r_scl_cnt == CW'(FILTER - 1)) begin
        r_scl_f   <= r_scl_s[1];
        r_scl_cnt <= '0;
      end else begin
        r_scl_cnt <= r_scl_cnt + 1'b1;
      end
      if (r_sda_s[1] == r_sda_f) begin
        r_sda_cnt <= '0;
      end else if (r_sda_cnt == CW'(FILTER - 1)) begin
        r_sda_f   <= r_sda_s[1];
        r_sda_cnt <= '0;
      end else begin
        r_sda_cnt <= r_sda_cnt + 1'b1;
      end
    end
  end

  assign w_scl_rise = r_scl_f & ~r_scl_d;
  assign w_scl_fall = ~r_scl_f & r_scl_d;
  assign w_start = r_scl_f & r_scl_d & r_sda_d & ~r_sda_f;
  assign w_stop  = r_scl_f & r_scl_d & ~r_sda_d & r_sda_f;
  assign w_byte  = {r_shift, r_sda_f};

  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_tx_nxt     = r_tx;
    w_oe_nxt     = r_oe;
    w_ackd_nxt   = r_ackd;
    w_rw_nxt     = r_rw;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_we_nxt     = 1'b0;
    w_re_nxt     = 1'b0;
    w_busy_nxt   = r_busy;
    // Pointer advances at the end of each strobe cycle.
    if (r_we || r_re) w_addr_nxt = r_addr + 8'd1;
    // Read data is captured while REG_RE is high and its
    // MSB goes straight onto the bus.
    if (r_re) begin
      w_tx_nxt = REG_RDATA[6:0];
      w_oe_nxt = ~REG_RDATA[7];
    end
    if (w_stop) begin
      w_state_nxt = S_IDLE;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = S_DEV;
      w_oe_nxt     = 1'b0;
      w_bitcnt_nxt = 3'd0;
      w_busy_nxt   = 1'b1;
    end else begin
      unique case (r_state)
        S_DEV, S_SUB, S_WR: begin
          if (w_scl_rise) begin
            w_shift_nxt  = w_byte[6:0];
            w_bitcnt_nxt = r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              w_ackd_nxt = 1'b0;
              if (r_state == S_DEV) begin
                w_rw_nxt    = w_byte[0];
                w_state_nxt = (w_byte[7:1] == DEV_ADDR) ?
                              S_ACK_DEV : S_IGNORE;
              end else if (r_state == S_SUB) begin
                w_addr_nxt  = w_byte;
                w_state_nxt = S_ACK_SUB;
              end else begin
                w_we_nxt    = 1'b1;
                w_wdata_nxt = w_byte;
                w_state_nxt = S_ACK_WR;
              end
            end
          end
        end
        // First fall starts the ACK drive, second ends it.
        S_ACK_DEV, S_ACK_SUB, S_ACK_WR: begin
          if (w_scl_fall) begin
            if (!r_ackd) begin
              w_oe_nxt   = 1'b1;
              w_ackd_nxt = 1'b1;
            end else begin
              w_oe_nxt     = 1'b0;
              w_bitcnt_nxt = 3'd0;
              if (r_state == S_ACK_DEV && r_rw) begin
                w_re_nxt    = 1'b1;
                w_state_nxt = S_RD;
              end else if (r_state == S_ACK_DEV) begin
                w_state_nxt = S_SUB;
              end else begin
                w_state_nxt = S_WR;
              end
            end
          end
        end
        S_RD: begin
          if (w_scl_rise) w_bitcnt_nxt = r_bitcnt + 3'd1;
          if (w_scl_fall) begin
            if (r_bitcnt == 3'd0) begin
              w_oe_nxt    = 1'b0;
              w_ackd_nxt  = 1'b0;
              w_state_nxt = S_RD_ACK;
            end else begin
              w_tx_nxt = {r_tx[5:0], 1'b0};
              w_oe_nxt = ~r_tx[6];
            end
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise) begin
            if (r_sda_f) w_state_nxt = S_IGNORE;
            else         w_ackd_nxt  = 1'b1;
          end
          if (w_scl_fall && r_ackd) begin
            w_re_nxt     = 1'b1;
            w_bitcnt_nxt = 3'd0;
            w_state_nxt  = S_RD;
          end
        end
        default: w_oe_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state  <= S_IDLE;
      r_bitcnt <= 3'd0;
      r_shift  <= 7'd0;
      r_tx     <= 7'd0;
      r_oe     <= 1'b0;
      r_ackd   <= 1'b0;
      r_rw     <= 1'b0;
      r_addr   <= 8'd0;
      r_wdata  <= 8'd0;
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_tx     <= w_tx_nxt;
      r_oe     <= w_oe_nxt;
      r_ackd   <= w_ackd_nxt;
      r_rw     <= w_rw_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_we     <= w_we_nxt;
      r_re     <= w_re_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign I2C_SDA   = r_oe ? 1'b0 : 1'bz;
  assign REG_ADDR  = r_addr;
  assign REG_WDATA = r_wdata;
  assign REG_WE    = r_we;
  assign REG_RE    = r_re;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bus-level initiator with a transaction
// model of the register pointer and expected strobes.
module tb_i2c_target;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic scl   = 1'b1;
  logic m_low = 1'b0;
  wire  sda;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic reg_we, reg_re, busy;

  int total = 0;
  int bad   = 0;
  int h     = 16;
  logic [7:0] m_ptr = 8'h00;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;
  ev_t exp_q[$];
  logic [7:0] rd_log[$];

  always #5 clk = ~clk;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;
  assign reg_rdata = reg_addr ^ 8'h5A;

  i2c_target dut (
    .iCLK(clk),
    .iRST_N(rst_n),
    .I2C_SCL(scl),
    .I2C_SDA(sda),
    .REG_ADDR(reg_addr),
    .REG_WDATA(reg_wdata),
    .REG_WE(reg_we),
    .REG_RDATA(reg_rdata),
    .REG_RE(reg_re),
    .BUSY(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Every strobe must match the next expected event.
  always @(negedge clk) begin
    if (rst_n && (reg_we || reg_re)) begin
      if (exp_q.size() == 0) begin
        chk("stray_strobe", 32'({reg_we, reg_re}), 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("strobe_kind", 32'({reg_we, reg_re}),
            e.we ? 32'd2 : 32'd1);
        chk("strobe_addr", 32'(reg_addr), 32'(e.addr));
        if (e.we) chk("wdata", 32'(reg_wdata), 32'(e.data));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, input logic g,
                       output logic s);
    cyc(h / 2);
    m_low = ~b;
    if (g) begin
      cyc(2);
      scl = 1'b1;
      cyc(3);
      scl = 1'b0;
    end
    cyc(h / 2);
    scl = 1'b1;
    cyc(h);
    s = sda;
    scl = 1'b0;
  endtask

  task automatic do_start();
    if (scl) begin
      cyc(h);
    end else begin
      cyc(h / 2);
      m_low = 1'b0;
      cyc(h / 2);
      scl = 1'b1;
      cyc(h / 2);
    end
    m_low = 1'b1;
    cyc(h);
    scl = 1'b0;
    chk("busy_set", 32'(busy), 32'd1);
  endtask

  task automatic do_stop();
    cyc(h / 2);
    m_low = 1'b1;
    cyc(h / 2);
    scl = 1'b1;
    cyc(h);
    m_low = 1'b0;
    cyc(h);
    chk("busy_clr", 32'(busy), 32'd0);
    chk("sda_idle", 32'(sda), 32'd1);
    chk("ptr", 32'(reg_addr), 32'(m_ptr));
    chk("strobes_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gi,
                           output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_x(b[i], i == gi, s);
      if (b[i]) chk("sda_free", 32'(s), 32'd1);
    end
    bit_x(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, 1'b0, s);
      d[i] = s;
    end
    bit_x(~ack, 1'b0, s);
  endtask

  task automatic wr_txn(input logic [7:0] sub,
                        input logic [7:0] d [4], input int n,
                        input int gi, input logic stp);
    logic a;
    ev_t e;
    do_start();
    send_byte(8'h72, -1, a);
    chk("ack_dev_w", 32'(a), 32'd1);
    send_byte(sub, -1, a);
    chk("ack_sub", 32'(a), 32'd1);
    m_ptr = sub;
    for (int k = 0; k < n; k++) begin
      e.we = 1'b1;
      e.addr = m_ptr;
      e.data = d[k];
      exp_q.push_back(e);
      m_ptr = m_ptr + 8'd1;
      send_byte(d[k], (k == 0) ? gi : -1, a);
      chk("ack_wr", 32'(a), 32'd1);
    end
    if (stp) do_stop();
  endtask

  task automatic rd_txn(input int n);
    logic a;
    logic [7:0] d;
    ev_t e;
    do_start();
    send_byte(8'h73, -1, a);
    chk("ack_dev_r", 32'(a), 32'd1);
    rd_log.delete();
    for (int k = 0; k < n; k++) begin
      e.we = 1'b0;
      e.addr = m_ptr + 8'(k);
      e.data = 8'h00;
      exp_q.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      recv_byte(k < n - 1, d);
      chk("rd_byte", 32'(d), 32'(m_ptr ^ 8'h5A));
      rd_log.push_back(d);
      m_ptr = m_ptr + 8'd1;
    end
    chk("nack_release", 32'(sda), 32'd1);
    do_stop();
  endtask

  task automatic bad_txn(input logic [7:0] a0, input int nb);
    logic a;
    do_start();
    send_byte(a0, -1, a);
    chk("nack_dev", 32'(a), 32'd0);
    for (int k = 0; k < nb; k++) begin
      send_byte(8'($urandom), -1, a);
      chk("nack_data", 32'(a), 32'd0);
    end
    do_stop();
  endtask

  initial begin
    logic [7:0] d [4];
    logic [7:0] b72;
    logic [7:0] a0;
    logic a, s;
    int kind;

    cyc(6);
    chk("rst_addr", 32'(reg_addr), 32'd0);
    chk("rst_wdata", 32'(reg_wdata), 32'd0);
    chk("rst_we", 32'(reg_we), 32'd0);
    chk("rst_re", 32'(reg_re), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sda", 32'(sda), 32'd1);
    rst_n = 1'b1;
    cyc(10);

    d = '{8'h03, 8'h00, 8'h00, 8'h00};
    wr_txn(8'h98, d, 1, -1, 1'b1);
    chk("lit_ptr_99", 32'(reg_addr), 32'h99);

    d = '{8'hAA, 8'hBB, 8'h00, 8'h00};
    wr_txn(8'hFF, d, 2, -1, 1'b1);
    chk("lit_wrap", 32'(reg_addr), 32'h01);

    bad_txn(8'h74, 2);
    chk("lit_bad_ptr", 32'(reg_addr), 32'h01);

    wr_txn(8'h10, d, 0, -1, 1'b0);
    rd_txn(2);
    chk("lit_rd0", 32'(rd_log[0]), 32'h4A);
    chk("lit_rd1", 32'(rd_log[1]), 32'h4B);
    chk("lit_rd_ptr", 32'(reg_addr), 32'h12);

    // partial byte ended by STOP
    wr_txn(8'h20, d, 0, -1, 1'b0);
    b72 = 8'hC3;
    for (int i = 7; i >= 3; i--) bit_x(b72[i], 1'b0, s);
    do_stop();
    chk("lit_abort_ptr", 32'(reg_addr), 32'h20);

    // SCL glitch during a data bit
    d = '{8'hA5, 8'h00, 8'h00, 8'h00};
    wr_txn(8'h30, d, 1, 3, 1'b1);
    chk("lit_glitch_ptr", 32'(reg_addr), 32'h31);

    // reset while the address ACK is driven
    do_start();
    b72 = 8'h72;
    for (int i = 7; i >= 0; i--) bit_x(b72[i], 1'b0, s);
    m_low = 1'b0;
    cyc(h / 2 + 4);
    chk("ack_driven", 32'(sda), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_sda_rel", 32'(sda), 32'd1);
    cyc(2);
    chk("rst2_addr", 32'(reg_addr), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    m_ptr = 8'h00;
    exp_q.delete();
    rst_n = 1'b1;
    cyc(2 * h);
    send_byte(8'h72, -1, a);
    chk("no_start_nack", 32'(a), 32'd0);
    do_stop();

    for (int it = 0; it < 20; it++) begin
      h = $urandom_range(16, 12);
      kind = $urandom_range(3, 0);
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
      case (kind)
        0: wr_txn(8'($urandom), d, $urandom_range(3, 0), -1, 1'b1);
        1: begin
          wr_txn(8'($urandom), d, $urandom_range(2, 0), -1, 1'b0);
          rd_txn($urandom_range(3, 1));
        end
        2: begin
          a0 = 8'($urandom);
          while (a0[7:1] == 7'h39) a0 = 8'($urandom);
          bad_txn(a0, $urandom_range(2, 0));
        end
        default: rd_txn($urandom_range(3, 1));
      endcase
    end

    cyc(20);
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
